// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle adder/subtractor that ripples CHUNK bits per
// clock, so a wide add meets timing with only CHUNK full-adder stages per cycle.
//
// Parameters:
//   WIDTH  operand/result width (multiple of CHUNK)
//   CHUNK  bits processed per cycle; N = WIDTH/CHUNK cycles per operation
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled when ready = 1
//   a, b   in   WIDTH-bit operands, sampled with start
//   c      in   carry-in (add) / borrow-in (sub), sampled with start
//   sub    in   0 = add, 1 = subtract, sampled with start
//   acc    in   (CHUNKED_ADDER_ACCUM_EN only) use current S as operand A
//   ready  out  high while idle
//   done   out  one-cycle pulse when S/Cout/V update
//   S      out  result, held until the next completion
//   Cout   out  raw carry-out of the MSB (1 = no borrow when subtracting)
//   V      out  signed two's-complement overflow
//
// Optional feature macro: CHUNKED_ADDER_ACCUM_EN adds the acc port.

module chunked_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             sub,
`ifdef CHUNKED_ADDER_ACCUM_EN
  input  logic             acc,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = CHUNK + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_sum;

  logic [WIDTH-1:0] w_a_src;
  logic [CW-1:0]    w_chunk;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  // Operand A source: the accumulator build can feed back the held result.
  always_comb begin
    w_a_src = a;
`ifdef CHUNKED_ADDER_ACCUM_EN
    if (acc) w_a_src = S;
`endif
  end

  // One CHUNK-wide ripple stage plus the partial sum with this chunk merged in.
  always_comb begin
    w_chunk = {1'b0, r_a[r_k*CHUNK +: CHUNK]} + {1'b0, r_b[r_k*CHUNK +: CHUNK]}
            + CW'(r_carry);
    w_sum_next = r_sum;
    w_sum_next[r_k*CHUNK +: CHUNK] = w_chunk[CHUNK-1:0];
    w_last = (r_k == KW'(N - 1));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtract as a + ~b + 1, with borrow-in folded into the carry.
            r_a     <= w_a_src;
            r_b     <= sub ? ~b : b;
            r_carry <= c ^ sub;
            r_k     <= '0;
            r_sum   <= '0;
            ready   <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_chunk[CHUNK];
          if (w_last) begin
            S       <= w_sum_next;
            Cout    <= w_chunk[CHUNK];
            V       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                       (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
            done    <= 1'b1;
            ready   <= 1'b1;
            r_k     <= '0;
            r_state <= IDLE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

- Parametrised multi-cycle adder/subtractor.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, carrying between chunks in an internal register. Ripple depth per cycle is CHUNK full-adder stages.
- Returns sum, carry-out and signed overflow with a start/ready/done handshake.
- Sits in the datapath wherever a wide add is needed but a full-width ripple chain would not meet timing.

## Interface

Parameters:

- WIDTH, default 16: operand and result width. Must be a multiple of CHUNK.
- CHUNK, default 4: bits processed per cycle. N = WIDTH/CHUNK cycles per operation. CHUNK = WIDTH is legal (N = 1).

Ports:

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when ready = 1
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- c  in  1  carry-in (add) / borrow-in (sub); sampled with start
- sub  in  1  0 = add, 1 = subtract; sampled with start
- ready  out  1  high in IDLE
- done  out  1  one-cycle pulse when S/Cout/V update
- S  out  WIDTH  result, held until the next completion
- Cout  out  1  carry-out of the MSB (raw adder carry)
- V  out  1  signed two's-complement overflow

## Operation

States:

- IDLE: ready = 1.
  - start = 1 latches a, b' = sub ? ~b : b, carry = c ^ sub, and sub.
  - Chunk index k = 0; go to RUN.
  - start = 0: stay in IDLE.
- RUN: ready = 0.
  - Each edge computes chunk k: {carry, sum[k]} = a[k] + b'[k] + carry. The chunk slice is bits k·CHUNK+CHUNK-1 down to k·CHUNK.
  - Increment k.
  - On the edge processing k = N-1:
    - S ← full sum.
    - Cout ← final carry.
    - V ← (a[MSB] == b'[MSB]) && (S[MSB] != a[MSB]).
    - done ← 1; return to IDLE.

Arithmetic rules:

- Add: S = (a + b + c) mod 2^WIDTH.
- Subtract: S = (a − b − c) mod 2^WIDTH.
- In subtract, Cout = 1 means no borrow.

Boundary conditions:

- start while ready = 0 is ignored; no queueing.
- Operand changes during RUN have no effect.
- S, Cout and V hold their last completed values through RUN. Partial sums live in an internal register, never on S.
- rst at any time, including mid-RUN, aborts the operation. Partial results are discarded, and reset values apply immediately.

## Timing

Reset values:

- ready = 1, done = 0.
- S = 0, Cout = 0, V = 0.
- Internal carry, k and partial sum = 0; state = IDLE.

Cycle-level behaviour:

- Accept edge E0 (start = 1, ready = 1). ready = 0 from E0.
- Chunks are processed on edges E1..EN. Results and done = 1 appear after EN; ready = 1 after EN.
- done is high for exactly one cycle, deasserted at EN+1.
- start asserted during the done cycle is accepted at EN+1.
- Maximum throughput: one operation per N+1 cycles.
- N = 1: result after E1, done pulse follows.

## Configuration

- Macro: CHUNKED_ADDER_ACCUM_EN.
- When defined:
  - Extra port: acc  in  1, sampled with start.
  - acc = 1 replaces operand A with the current S register, giving running accumulation: S ← S ± b ± c.
  - acc = 0 behaves exactly as without the macro.
- When undefined:
  - The acc port does not exist.
  - Operand A always comes from a.
- Timing and latency are identical in both builds.

## Test plan

All scenarios use WIDTH = 16, CHUNK = 4 (N = 4).

1. Add: a = 0x1234, b = 0x4321, c = 0, sub = 0, start.
   - Required: done one cycle after the 4th edge after acceptance.
   - S = 0x5555, Cout = 0, V = 0; ready low for exactly 4 cycles.
2. Carry chain across all chunks:
   - 0xFFFF + 0x0001, c = 0 → S = 0x0000, Cout = 1, V = 0.
   - 0x7FFF + 0x0000, c = 1 → S = 0x8000, Cout = 0, V = 1.
3. Subtract: a = 0x0005, b = 0x0007, c = 0, sub = 1.
   - Required: S = 0xFFFE, Cout = 0, V = 0.
   - Then a = 0x8000, b = 0x0001, c = 0, sub = 1 → S = 0x7FFF, Cout = 1, V = 1.
4. Busy and back-to-back: start a second op (0x0001 + 0x0001) two cycles after acceptance of test 1.
   - Required: it is ignored; S = 0x5555 on completion.
   - Re-asserting start in the done cycle gives S = 0x0002 exactly 5 cycles later.
5. Reset mid-op: rst pulsed after edge E2 of an add.
   - Required: immediately ready = 1, done = 0, S = 0, Cout = 0, V = 0.
   - No done pulse follows.
   - A fresh 0x00FF + 0x0001 then yields 0x0100.
6. CHUNKED_ADDER_ACCUM_EN defined: reset, then three ops with acc = 1, b = 0x4000, c = 0, sub = 0.
   - Required: S = 0x4000, 0x8000 (V = 1), then 0xC000.
   - The same sequence with acc = 0 and a = 0 gives 0x4000 each time.
